dma_s2mm_ctrl: RTL and testbench

DMA_S2MM_CTRL -- requirements
Module: dma_s2mm_ctrl

---
 rtl/dma_s2mm_ctrl_if.sv | 41 ++++
 rtl/dma_s2mm_ctrl.sv | 144 ++++++++++++++
 tb/tb_dma_s2mm_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_s2mm_ctrl_if.sv
// AXI4 write-address, write-data and write-response channels used by the
// S2MM controller; the master modport belongs to the controller.
interface dma_s2mm_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   m_awaddr;
    logic [7:0]              m_awlen;
    logic [2:0]              m_awsize;
    logic [1:0]              m_awburst;
    logic                    m_awvalid;
    logic                    m_awready;

    logic [DATA_WIDTH-1:0]   m_wdata;
    logic [DATA_WIDTH/8-1:0] m_wstrb;
    logic                    m_wlast;
    logic                    m_wvalid;
    logic                    m_wready;

    logic [1:0]              m_bresp;
    logic                    m_bvalid;
    logic                    m_bready;

    modport master (
        output m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
        input  m_awready,
        output m_wdata, m_wstrb, m_wlast, m_wvalid,
        input  m_wready,
        input  m_bresp, m_bvalid,
        output m_bready
    );

    modport slave (
        input  m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
        output m_awready,
        input  m_wdata, m_wstrb, m_wlast, m_wvalid,
        output m_wready,
        output m_bresp, m_bvalid,
        input  m_bready
    );
endinterface

// File: rtl/dma_s2mm_ctrl.sv
// Stream-to-memory DMA: drains a FIFO into AXI4 INCR write bursts, splitting
// each transfer at MAX_BURST beats and at 4 KB address boundaries.
module dma_s2mm_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [15:0]           xfer_len,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    dma_s2mm_ctrl_if.master       m_axi
);
    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned SIZE  = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           rem_q, rem_d;
    logic [7:0]            awlen_q;
    logic [7:0]            beat_q, beat_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic                  wvalid;
    logic [8:0]            beats;
    logic [12:0]           room_bytes;
    logic [16:0]           room_words;
    logic [16:0]           burst_len;

    assign wvalid = (state_q == S_DATA) && !fifo_empty;
    assign beats  = {1'b0, awlen_q} + 9'd1;

    // Sized from the next-cycle address/remaining so awlen is ready on ADDR entry.
    always_comb begin
        room_bytes = 13'h1000 - {1'b0, addr_d[11:0]};
        room_words = 17'(room_bytes >> SIZE);
        burst_len  = 17'(MAX_BURST);
        if ({1'b0, rem_d} < burst_len) burst_len = {1'b0, rem_d};
        if (room_words < burst_len)    burst_len = room_words;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        beat_d  = beat_q;
        done_d  = 1'b0;
        error_d = error_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    if (xfer_len == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d  = start_addr & ALIGN_MASK;
                        rem_d   = xfer_len;
                        state_d = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (m_axi.m_awready) begin
                    beat_d  = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (wvalid && m_axi.m_wready) begin
                    beat_d = beat_q + 8'd1;
                    if (beat_q == awlen_q) state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (m_axi.m_bvalid) begin
                    addr_d = addr_q + (ADDR_WIDTH'(beats) << SIZE);
                    rem_d  = rem_q - 16'(beats);
                    if (m_axi.m_bresp != 2'b00) begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else if (rem_d == '0) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ADDR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            awlen_q <= '0;
            beat_q  <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
            error_q <= error_d;
            if (state_d == S_ADDR && state_q != S_ADDR)
                awlen_q <= 8'(burst_len - 17'd1);
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign error      = error_q;
    assign fifo_rd_en = wvalid && m_axi.m_wready;

    assign m_axi.m_awaddr  = addr_q;
    assign m_axi.m_awlen   = awlen_q;
    assign m_axi.m_awsize  = 3'(SIZE);
    assign m_axi.m_awburst = 2'b01;
    assign m_axi.m_awvalid = (state_q == S_ADDR);
    assign m_axi.m_wdata   = fifo_dout;
    assign m_axi.m_wstrb   = '1;
    assign m_axi.m_wvalid  = wvalid;
    assign m_axi.m_wlast   = (state_q == S_DATA) && (beat_q == awlen_q);
    assign m_axi.m_bready  = (state_q == S_RESP);
endmodule

// File: tb/tb_dma_s2mm_ctrl.sv
// Self-checking bench for dma_s2mm_ctrl: directed table, randomized transfers
// against a burst-splitting reference model, and reset/zero-length sequences.
`timescale 1ns/1ps
module tb_dma_s2mm_ctrl;
    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [15:0]   xfer_len;
    logic          busy, done, error;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_dout;
    logic          fifo_empty;

    always #5 clk = ~clk;

    dma_s2mm_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) axi ();

    dma_s2mm_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .start_addr (start_addr),
        .xfer_len   (xfer_len),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .m_axi      (axi)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference model: split a transfer into bursts by plain arithmetic.
    logic [31:0] exp_a[$];
    int          exp_l[$];
    function automatic void model(input logic [31:0] a, input int len);
        logic [31:0] cur;
        int r, n, room;
        exp_a.delete();
        exp_l.delete();
        cur = a & ~32'h3;
        r = len;
        while (r > 0) begin
            room = (4096 - int'(cur % 4096)) / 4;
            n = r;
            if (n > 16) n = 16;
            if (n > room) n = room;
            exp_a.push_back(cur);
            exp_l.push_back(n);
            cur = cur + 32'(4 * n);
            r = r - n;
        end
    endfunction

    logic [31:0] fifo_q[$];
    logic [31:0] word_log[$];
    logic [31:0] obs_a[$];
    int          obs_l[$];

    task automatic do_xfer(input logic [31:0] a, input int len, input int err_burst,
                           input bit rnd, input int gap_at, input bit busy_starts,
                           output int n_bursts, output int first_len, output int n_pops);
        int n_exp, exp_pops, pops, beat_in, bidx, b_pend, b_idx, done_cnt, post, gap_cnt;
        int data_viol, wlast_viol, rd_viol, stable_viol, cross_viol;
        bit seen_done, gap_used, aw_hold, exp_err;
        logic [31:0] hold_a, w;
        logic [7:0]  hold_l;

        model(a, len);
        n_exp = exp_a.size();
        exp_err = (err_burst >= 0) && (err_burst < n_exp);
        if (exp_err) n_exp = err_burst + 1;
        exp_pops = 0;
        for (int i = 0; i < n_exp; i++) exp_pops += exp_l[i];

        fifo_q.delete(); word_log.delete(); obs_a.delete(); obs_l.delete();
        for (int i = 0; i < len; i++) begin
            w = $urandom;
            fifo_q.push_back(w);
            word_log.push_back(w);
        end
        pops = 0; beat_in = 0; bidx = 0; b_pend = 0; b_idx = 0; done_cnt = 0; post = 0;
        gap_cnt = 0; data_viol = 0; wlast_viol = 0; rd_viol = 0; stable_viol = 0; cross_viol = 0;
        seen_done = 0; gap_used = 0; aw_hold = 0; hold_a = '0; hold_l = '0;

        start = 1'b1; start_addr = a; xfer_len = 16'(len);
        for (int cyc = 0; cyc < 4000 && post < 4; cyc++) begin
            if (cyc > 0) begin
                start      = busy_starts && busy && ($urandom_range(0, 5) == 0);
                start_addr = $urandom;
                xfer_len   = 16'($urandom_range(0, 40));
            end
            axi.m_awready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            axi.m_wready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            fifo_empty    = (fifo_q.size() == 0) || (gap_cnt > 0);
            fifo_dout     = (fifo_q.size() != 0) ? fifo_q[0] : 32'hDEAD_BEEF;
            if (gap_cnt > 0) gap_cnt--;
            axi.m_bvalid  = (b_pend > 0) && (!rnd || $urandom_range(0, 2) == 0);
            axi.m_bresp   = (b_idx == err_burst) ? 2'b10 : 2'b00;

            @(negedge clk);
            if (done) begin done_cnt++; seen_done = 1; end
            if (seen_done) post++;
            if (aw_hold && (!axi.m_awvalid || axi.m_awaddr != hold_a || axi.m_awlen != hold_l))
                stable_viol++;
            aw_hold = axi.m_awvalid && !axi.m_awready;
            hold_a  = axi.m_awaddr;
            hold_l  = axi.m_awlen;
            if (axi.m_awvalid && axi.m_awready) begin
                obs_a.push_back(axi.m_awaddr);
                obs_l.push_back(int'(axi.m_awlen));
                if (int'(axi.m_awaddr[11:0]) + (int'(axi.m_awlen) + 1) * 4 > 4096) cross_viol++;
            end
            if ((fifo_rd_en != (axi.m_wvalid && axi.m_wready)) || (axi.m_wvalid && fifo_empty))
                rd_viol++;
            if (axi.m_wvalid && axi.m_wready) begin
                if (pops >= len || axi.m_wdata != word_log[pops]) data_viol++;
                if (bidx < exp_l.size()) begin
                    if (axi.m_wlast != (beat_in == exp_l[bidx] - 1)) wlast_viol++;
                end else begin
                    wlast_viol++;
                end
                if (axi.m_wlast) begin beat_in = 0; bidx++; b_pend++; end
                else beat_in++;
            end
            if (fifo_rd_en && fifo_q.size() > 0) begin
                void'(fifo_q.pop_front());
                pops++;
                if (pops == gap_at && !gap_used) begin gap_cnt = 5; gap_used = 1; end
            end
            if (axi.m_bvalid && axi.m_bready) begin b_pend--; b_idx++; end
            @(posedge clk); #1;
        end
        start = 1'b0;
        axi.m_bvalid = 1'b0;

        check("timeout", seen_done, 1);
        check("done_pulses", done_cnt, 1);
        check("aw_count", obs_a.size(), n_exp);
        for (int i = 0; i < n_exp && i < obs_a.size(); i++) begin
            check("aw_addr", obs_a[i], exp_a[i]);
            check("aw_len", obs_l[i], exp_l[i] - 1);
        end
        check("pops", pops, exp_pops);
        check("fifo_left", fifo_q.size(), len - exp_pops);
        check("wdata_order", data_viol, 0);
        check("wlast_pos", wlast_viol, 0);
        check("rd_en_rule", rd_viol, 0);
        check("aw_stable", stable_viol, 0);
        check("no_4k_cross", cross_viol, 0);
        check("error_flag", error, exp_err);
        check("busy_after", busy, 0);
        n_bursts  = obs_a.size();
        first_len = (obs_l.size() != 0) ? obs_l[0] : -1;
        n_pops    = pops;
    endtask

    typedef struct {
        logic [31:0] addr;
        int          len;
        int          err_burst;
        bit          rnd;
        int          gap;
        int          exp_bursts;
        int          exp_first_len;
        int          exp_pops;
        bit          exp_err;
    } vec_t;

    vec_t tbl[6];
    int   nb, fl, np, ndone;

    initial begin
        tbl[0] = '{32'h0000_0000, 40, -1, 1'b0, -1, 3, 15, 40, 1'b0};
        tbl[1] = '{32'h0000_0FF8,  8, -1, 1'b0, -1, 2,  1,  8, 1'b0};
        tbl[2] = '{32'h0000_0100, 16, -1, 1'b1,  5, 1, 15, 16, 1'b0};
        tbl[3] = '{32'h0000_1003,  3, -1, 1'b1, -1, 1,  2,  3, 1'b0};
        tbl[4] = '{32'h0000_0FFC,  1, -1, 1'b0, -1, 1,  0,  1, 1'b0};
        tbl[5] = '{32'h0000_0200, 32,  0, 1'b0, -1, 1, 15, 16, 1'b1};

        reset_n = 1'b0; start = 1'b0; start_addr = '0; xfer_len = '0;
        fifo_empty = 1'b1; fifo_dout = '0;
        axi.m_awready = 1'b0; axi.m_wready = 1'b0; axi.m_bvalid = 1'b0; axi.m_bresp = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_valids", {axi.m_awvalid, axi.m_wvalid, axi.m_wlast, axi.m_bready, fifo_rd_en}, 0);
        check("rst_awaddr", axi.m_awaddr, 0);
        check("rst_awlen", axi.m_awlen, 0);
        check("awsize", axi.m_awsize, 2);
        check("awburst", axi.m_awburst, 1);
        check("wstrb", axi.m_wstrb, 4'hF);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            do_xfer(tbl[i].addr, tbl[i].len, tbl[i].err_burst, tbl[i].rnd, tbl[i].gap, 1'b0, nb, fl, np);
            check("tbl_bursts", nb, tbl[i].exp_bursts);
            check("tbl_first_awlen", fl, tbl[i].exp_first_len);
            check("tbl_pops", np, tbl[i].exp_pops);
            check("tbl_error", error, tbl[i].exp_err);
            @(posedge clk); #1;
        end

        // Error from the last table entry must hold until the next accepted start.
        repeat (5) @(posedge clk);
        #1;
        check("error_hold", error, 1);

        start = 1'b1; xfer_len = 16'd0; start_addr = 32'h40;
        @(negedge clk);
        check("zl_done_early", done, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("zl_done", done, 1);
        check("zl_awvalid", axi.m_awvalid, 0);
        check("zl_busy", busy, 0);
        check("zl_error_clr", error, 0);
        @(negedge clk);
        check("zl_done_once", done, 0);
        @(posedge clk); #1;

        for (int t = 0; t < 10; t++) begin
            logic [31:0] ra;
            int rl, re, rg;
            ra = 32'($urandom_range(0, 3) << 12) | 32'($urandom_range(0, 4095));
            rl = $urandom_range(1, 60);
            re = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
            rg = ($urandom_range(0, 1) == 1) ? $urandom_range(1, rl) : -1;
            do_xfer(ra, rl, re, 1'b1, rg, 1'b1, nb, fl, np);
            @(posedge clk); #1;
        end

        fifo_empty = 1'b1; axi.m_awready = 1'b1; axi.m_wready = 1'b1; axi.m_bvalid = 1'b0;
        start = 1'b1; start_addr = 32'h300; xfer_len = 16'd16;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        fifo_empty = 1'b0; fifo_dout = 32'h1234_5678;
        @(negedge clk);
        check("rst_mid_in_data", axi.m_wvalid, 1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_awvalid", axi.m_awvalid, 0);
        check("rst_mid_wvalid", axi.m_wvalid, 0);
        check("rst_mid_wlast", axi.m_wlast, 0);
        check("rst_mid_bready", axi.m_bready, 0);
        check("rst_mid_rd_en", fifo_rd_en, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_awlen", axi.m_awlen, 0);
        fifo_empty = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done || busy || axi.m_awvalid) ndone++;
        end
        check("rst_no_done_after", ndone, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
